// File: rtl/vrms_scheduler.sv
// Shares one RMS engine across CH channels: selects, settles, frames a 2^BIT_POINTS window,
// then banks the engine's result per channel and raises irq at the end of each sweep.
module vrms_scheduler #(
    parameter int DW         = 12,
    parameter int CH         = 4,
    parameter int BIT_POINTS = 8,
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk_fs,
    input  logic                   rst,
    input  logic [CH*DW-1:0]       data_s,
    input  logic [CH-1:0]          en_mask,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   abort,
    output logic [DW-1:0]          eng_data,
    output logic                   eng_first,
    output logic                   eng_last,
    input  logic [DW-2:0]          eng_rms,
    input  logic                   eng_valid,
    input  logic [$clog2(CH)-1:0]  rd_ch,
    output logic [DW-2:0]          rd_rms,
    output logic                   busy,
    output logic [CH-1:0]          fault,
    output logic                   irq
);

    localparam int CHW = $clog2(CH);
    localparam int WCW = BIT_POINTS + 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WIN_LAST = WCW'((1 << BIT_POINTS) - 1);
    localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE - 1);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SETTLE, S_ACQ, S_WAIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic [CHW:0]           ptr_q, ptr_d;
    logic [CH-1:0]          mask_q, mask_d;
    logic [SCW-1:0]         set_cnt_q, set_cnt_d;
    logic [WCW-1:0]         win_cnt_q, win_cnt_d;
    logic [TCW-1:0]         to_cnt_q, to_cnt_d;
    logic [DW-1:0]          eng_data_q, eng_data_d;
    logic                   eng_first_q, eng_first_d;
    logic                   eng_last_q, eng_last_d;
    logic                   irq_q, irq_d;
    logic [CH-1:0]          fault_q, fault_d;
    logic [CH-1:0][DW-2:0]  bank_q, bank_d;

    logic [DW-1:0]          sel_sample;
    logic                   found;
    logic [CHW-1:0]         nxt_ch;

    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < CH; k++)
            if (ch_q == CHW'(k)) sel_sample = data_s[k*DW +: DW];
    end

    // Descending scan so the last hit is the lowest enabled channel at or above the pointer.
    always_comb begin
        found  = 1'b0;
        nxt_ch = '0;
        for (int k = CH - 1; k >= 0; k--)
            if (mask_q[k] && k >= int'(ptr_q)) begin
                found  = 1'b1;
                nxt_ch = CHW'(k);
            end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        set_cnt_d   = set_cnt_q;
        win_cnt_d   = win_cnt_q;
        to_cnt_d    = to_cnt_q;
        eng_data_d  = sel_sample;
        eng_first_d = 1'b0;
        eng_last_d  = 1'b0;
        irq_d       = irq_q;
        fault_d     = fault_q;
        bank_d      = bank_q;
        case (state_q)
            S_IDLE: if (start && (en_mask != '0)) begin
                mask_d  = en_mask;
                fault_d = '0;
                irq_d   = 1'b0;
                ptr_d   = '0;
                state_d = S_SEL;
            end
            S_SEL: if (found) begin
                ch_d      = nxt_ch;
                set_cnt_d = '0;
                win_cnt_d = '0;
                state_d   = (SETTLE == 0) ? S_ACQ : S_SETTLE;
            end else begin
                state_d = S_DONE;
            end
            S_SETTLE: if (set_cnt_q == SET_LAST) state_d = S_ACQ;
                      else set_cnt_d = set_cnt_q + SCW'(1);
            S_ACQ: begin
                eng_first_d = (win_cnt_q == '0);
                eng_last_d  = (win_cnt_q == WIN_LAST);
                if (win_cnt_q == WIN_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end else begin
                    win_cnt_d = win_cnt_q + WCW'(1);
                end
            end
            S_WAIT: if (eng_valid) begin
                bank_d[ch_q] = eng_rms;
                ptr_d        = {1'b0, ch_q} + (CHW+1)'(1);
                state_d      = S_SEL;
            end else if (to_cnt_q == TO_LAST) begin
                // Engine never answered: bank a zero and flag the channel, but keep the sweep going.
                bank_d[ch_q]  = '0;
                fault_d[ch_q] = 1'b1;
                ptr_d         = {1'b0, ch_q} + (CHW+1)'(1);
                state_d       = S_SEL;
            end else begin
                to_cnt_d = to_cnt_q + TCW'(1);
            end
            S_DONE: begin
                irq_d = 1'b1;
                if (cont) begin
                    mask_d  = en_mask;
                    ptr_d   = '0;
                    state_d = (en_mask != '0) ? S_SEL : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d     = S_IDLE;
            eng_first_d = 1'b0;
            eng_last_d  = 1'b0;
            irq_d       = 1'b0;
            fault_d     = fault_q;
            bank_d      = bank_q;
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            ptr_q       <= '0;
            mask_q      <= '0;
            set_cnt_q   <= '0;
            win_cnt_q   <= '0;
            to_cnt_q    <= '0;
            eng_data_q  <= '0;
            eng_first_q <= 1'b0;
            eng_last_q  <= 1'b0;
            irq_q       <= 1'b0;
            fault_q     <= '0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            set_cnt_q   <= set_cnt_d;
            win_cnt_q   <= win_cnt_d;
            to_cnt_q    <= to_cnt_d;
            eng_data_q  <= eng_data_d;
            eng_first_q <= eng_first_d;
            eng_last_q  <= eng_last_d;
            irq_q       <= irq_d;
            fault_q     <= fault_d;
            bank_q      <= bank_d;
        end
    end

    assign eng_data  = eng_data_q;
    assign eng_first = eng_first_q;
    assign eng_last  = eng_last_q;
    assign irq       = irq_q;
    assign fault     = fault_q;
    assign busy      = (state_q != S_IDLE);
    assign rd_rms    = bank_q[rd_ch];

endmodule

// File: tb/tb_vrms_scheduler.sv
// Bench for vrms_scheduler: behavioural RMS engine plus a window scoreboard of expected first samples.
module tb_vrms_scheduler;

    localparam int DW = 12, CH = 4, BP = 8, SETTLE = 4, TIMEOUT = 64;
    localparam int WIN = 1 << BP;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CH*DW-1:0]     data_s = '0;
    logic [CH-1:0]        en_mask = '0;
    logic                 start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic signed [DW-1:0] eng_data;
    logic                 eng_first, eng_last;
    logic [DW-2:0]        eng_rms = '0;
    logic                 eng_valid = 1'b0;
    logic [1:0]           rd_ch = '0;
    logic [DW-2:0]        rd_rms;
    logic                 busy, irq;
    logic [CH-1:0]        fault;

    vrms_scheduler #(.DW(DW), .CH(CH), .BIT_POINTS(BP), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk_fs(clk), .rst(rst), .data_s(data_s), .en_mask(en_mask), .start(start), .cont(cont),
        .abort(abort), .eng_data(eng_data), .eng_first(eng_first), .eng_last(eng_last),
        .eng_rms(eng_rms), .eng_valid(eng_valid), .rd_ch(rd_ch), .rd_rms(rd_rms), .busy(busy),
        .fault(fault), .irq(irq)
    );

    always #5 clk = ~clk;

    int  n_chk = 0, n_err = 0;
    int  cyc = 0;
    int  dc [CH] = '{1000, 300, -500, 700};
    real amp [CH] = '{2040.0, 1500.0, 1000.0, 500.0};
    bit  sine_mode = 0, sb_on = 1, mute_en = 0;
    int  mute_val = 300, eng_delay = 3;
    int  sb [$];
    int  t_start = 0, lat_tag = 0, lat_done = 0;
    int  n_first = 0, n_last = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus: per-channel DC level or a 32-sample-period sine.
    int n_samp = 0;
    always @(negedge clk) begin
        n_samp++;
        for (int k = 0; k < CH; k++) begin
            real x;
            int  v;
            x = amp[k] * $sin(2.0 * 3.14159265358979 * real'(n_samp % 32) / 32.0);
            v = sine_mode ? $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5)) : dc[k];
            data_s[k*DW +: DW] = DW'(v);
        end
    end

    // Behavioural engine; a pending result survives rst so it can arrive late.
    longint acc = 0;
    bit     in_win = 0;
    int     first_s = 0, pend_cnt = 0;
    longint pend_val = 0;
    always @(negedge clk) begin
        eng_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                eng_valid = 1'b1;
                eng_rms   = (DW-1)'(pend_val);
            end
        end
        if (eng_first) begin
            acc     = 0;
            in_win  = 1;
            first_s = int'(eng_data);
        end
        if (in_win) acc += longint'(eng_data) * longint'(eng_data);
        if (eng_last) begin
            in_win = 0;
            if (!(mute_en && first_s == mute_val)) begin
                pend_cnt = eng_delay;
                pend_val = isqrt(acc >>> BP);
            end
        end
    end

    // Monitor: pops the scoreboard at each window start, checks latency and window length.
    bit mon_win = 0;
    int wpos = 0;
    always @(negedge clk) begin
        if (eng_first) begin
            n_first++;
            wpos    = 0;
            mon_win = 1;
            if (sb_on) begin
                chk("sb_nonempty", longint'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("first_sample", eng_data, sb.pop_front());
            end
            if (lat_tag != lat_done) begin
                chk("first_latency", cyc - t_start, 3 + SETTLE);
                lat_done = lat_tag;
            end
        end else if (mon_win) begin
            wpos++;
        end
        if (eng_last) begin
            n_last++;
            mon_win = 0;
            chk("window_len", wpos, WIN - 1);
        end
    end

    task automatic do_start(input bit timed);
        @(negedge clk);
        start = 1'b1;
        if (timed) begin
            t_start = cyc;
            lat_tag++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_bank(input string tag, input int ch, input int exp);
        rd_ch = 2'(ch);
        #1;
        chk(tag, rd_rms, exp);
    endtask

    task automatic wait_irq(input int lim);
        for (int i = 0; i < lim && !irq; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
    endtask

    initial begin
        int nf, nl;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_fault", fault, 0);
        chk("rst_first", eng_first, 0);
        chk("rst_last", eng_last, 0);
        chk("rst_data", eng_data, 0);
        for (int k = 0; k < CH; k++) chk_bank("rst_bank", k, 0);
        rst = 1'b0;

        // mask 0101: ch0 and ch2 only
        en_mask = 4'b0101;
        sb.push_back(1000); sb.push_back(-500);
        nf = n_first; nl = n_last;
        do_start(1);
        wait_irq(2000);
        chk("s1_irq", irq, 1);
        chk("s1_busy", busy, 0);
        chk("s1_pairs_first", n_first - nf, 2);
        chk("s1_pairs_last", n_last - nl, 2);
        chk_bank("s1_bank0", 0, 1000);
        chk_bank("s1_bank1", 1, 0);
        chk_bank("s1_bank2", 2, 500);
        chk_bank("s1_bank3", 3, 0);
        chk("s1_fault", fault, 0);
        chk("s1_sb_empty", sb.size(), 0);

        // all four channels
        en_mask = 4'b1111;
        for (int k = 0; k < CH; k++) sb.push_back(dc[k]);
        do_start(1);
        chk("s2_irq_cleared", irq, 0);
        wait_irq(3000);
        chk("s2_irq", irq, 1);
        chk_bank("s2_bank0", 0, 1000);
        chk_bank("s2_bank1", 1, 300);
        chk_bank("s2_bank2", 2, 500);
        chk_bank("s2_bank3", 3, 700);

        // abort during ch1 acquisition: ch0 refreshes, ch1 keeps its old result
        dc[0] = 1100; dc[1] = 900;
        sb.push_back(1100); sb.push_back(900);
        nf = n_first;
        do_start(1);
        for (int i = 0; i < 2000 && n_first < nf + 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        nl = n_last;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_irq", irq, 0);
        chk("ab_first", eng_first, 0);
        chk("ab_last", eng_last, 0);
        repeat (300) @(negedge clk);
        chk("ab_no_last", n_last - nl, 0);
        chk("ab_still_idle", busy, 0);
        chk_bank("ab_bank0", 0, 1100);
        chk_bank("ab_bank1", 1, 300);
        chk("ab_sb_empty", sb.size(), 0);

        // engine never answers for ch1 -> timeout
        dc[0] = 1000; dc[1] = 300;
        mute_en = 1;
        for (int k = 0; k < CH; k++) sb.push_back(dc[k]);
        do_start(1);
        wait_irq(4000);
        chk("to_irq", irq, 1);
        chk("to_fault", fault, 4'b0010);
        chk_bank("to_bank0", 0, 1000);
        chk_bank("to_bank1", 1, 0);
        chk_bank("to_bank2", 2, 500);
        chk_bank("to_bank3", 3, 700);
        mute_en = 0;

        // continuous sweeps on sines
        sine_mode = 1; sb_on = 0; cont = 1'b1;
        do_start(1);
        chk("ct_fault_cleared", fault, 0);
        wait_irq(3000);
        chk("ct_irq_first", irq, 1);
        repeat (300) @(negedge clk);
        chk("ct_busy", busy, 1);
        chk("ct_irq_held", irq, 1);
        nf = n_first;
        for (int i = 0; i < 3000 && n_first < nf + 4; i++) @(negedge clk);
        cont = 1'b0;
        wait_idle(3000);
        chk("ct_idle", busy, 0);
        chk("ct_irq_end", irq, 1);
        for (int k = 0; k < CH; k++) begin
            int e, d;
            e = $rtoi(amp[k] * 0.70710678 + 0.5);
            rd_ch = 2'(k);
            #1;
            d = int'(rd_rms) - e;
            if (d < 0) d = -d;
            chk($sformatf("ct_rms_ch%0d_within2_of_%0d_got_%0d", k, e, rd_rms), longint'(d <= 2), 1);
        end

        // start with empty mask: nothing happens
        en_mask = 4'b0000;
        nf = n_first;
        do_start(0);
        chk("m0_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("m0_busy_later", busy, 0);
        chk("m0_no_window", n_first - nf, 0);

        // rst while waiting for the engine; its late answer must not land
        sine_mode = 0; sb_on = 1; eng_delay = 20;
        en_mask = 4'b0001;
        sb.push_back(1000);
        nl = n_last;
        do_start(1);
        for (int i = 0; i < 1000 && n_last < nl + 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rw_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_busy", busy, 0);
        chk("rw_irq", irq, 0);
        chk("rw_fault", fault, 0);
        chk("rw_first", eng_first, 0);
        chk("rw_last", eng_last, 0);
        chk("rw_data", eng_data, 0);
        for (int k = 0; k < CH; k++) chk_bank("rw_bank", k, 0);
        repeat (30) @(negedge clk);
        chk_bank("rw_late_bank0", 0, 0);
        chk("rw_late_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
